adsr_envelope_gen: RTL and testbench

- Parametrised ADSR envelope generator for the synth voice path.
- Replaces the fixed 8-bit, one-step-per-phase envelope with:
  - programmable level width;
  - a per-voice prescaled tick;
  - per-phase step sizes, saturating arithmetic, retrigger and early release.
- Sits between the note/key controller (note_on/note_off pulses) and the voice amplitude multiplier, which consumes level.

---
 rtl/adsr_envelope_gen_if.sv | 54 +++++
 rtl/adsr_envelope_gen.sv | 157 +++++++++++++++
 tb/tb_adsr_envelope_gen.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adsr_envelope_gen_if.sv
// ---------------------------------------------------------------------------
// adsr_envelope_gen_if
//   Bundle between the note/key controller (master) and the ADSR envelope
//   generator (slave).
//
//   Event protocol: note_on and note_off are single-cycle pulses sampled on
//   the rising clock edge. There is no ready/backpressure: the envelope
//   accepts every pulse on the cycle it is presented. The configuration
//   fields are sampled only on the edge where note_on is high and may change
//   freely at all other times. level/phase/busy/tick are registered outputs.
//
//   Ports (signals):
//     note_on        master->slave  start or retrigger envelope
//     note_off       master->slave  enter release
//     prescale       master->slave  tick period minus one, in clk cycles
//     peak_level     master->slave  attack target
//     sustain_level  master->slave  decay target / hold level
//     attack_step    master->slave  level increment per tick, 0 = instant
//     decay_step     master->slave  level decrement per tick, 0 = instant
//     release_step   master->slave  level decrement per tick, 0 = instant
//     level          slave->master  registered envelope value
//     phase          slave->master  one-hot {RELEASE,SUSTAIN,DECAY,ATTACK,IDLE}
//     busy           slave->master  high whenever phase != IDLE
//     tick           slave->master  registered copy of the update strobe
// ---------------------------------------------------------------------------
interface adsr_envelope_gen_if #(
    parameter int W  = 8,
    parameter int RW = 16
);
    logic          note_on;
    logic          note_off;
    logic [RW-1:0] prescale;
    logic [W-1:0]  peak_level;
    logic [W-1:0]  sustain_level;
    logic [W-1:0]  attack_step;
    logic [W-1:0]  decay_step;
    logic [W-1:0]  release_step;
    logic [W-1:0]  level;
    logic [4:0]    phase;
    logic          busy;
    logic          tick;

    modport master (
        output note_on, note_off, prescale, peak_level, sustain_level,
               attack_step, decay_step, release_step,
        input  level, phase, busy, tick
    );

    modport slave (
        input  note_on, note_off, prescale, peak_level, sustain_level,
               attack_step, decay_step, release_step,
        output level, phase, busy, tick
    );
endinterface

// File: rtl/adsr_envelope_gen.sv
// ---------------------------------------------------------------------------
// adsr_envelope_gen
//   Parametrised ADSR envelope generator for one synth voice. A prescaler
//   produces an update strobe every (prescale+1) cycles while the envelope is
//   active; each strobe moves the level one step towards the current phase
//   target with saturating arithmetic. note_on retriggers legato from the
//   current level, note_off releases early from the current level.
//
//   Ports:
//     clk    system clock
//     rst_b  asynchronous active-low reset
//     bus    adsr_envelope_gen_if.slave (events, config, level/phase/busy/tick)
//
//   The FSM state is the phase output itself (one-hot), so it is always
//   visible for debug.
// ---------------------------------------------------------------------------
module adsr_envelope_gen #(
    parameter int W  = 8,
    parameter int RW = 16
) (
    input  logic               clk,
    input  logic               rst_b,
    adsr_envelope_gen_if.slave bus
);

    localparam logic [4:0] ST_IDLE    = 5'b00001;
    localparam logic [4:0] ST_ATTACK  = 5'b00010;
    localparam logic [4:0] ST_DECAY   = 5'b00100;
    localparam logic [4:0] ST_SUSTAIN = 5'b01000;
    localparam logic [4:0] ST_RELEASE = 5'b10000;

    logic [4:0]    state_q, state_d;
    logic [W-1:0]  level_q, level_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic          busy_q;
    logic          tick_q;

    // Configuration latched on note_on. sus_q holds the effective sustain
    // target, already clamped to the peak so decay never has to climb.
    logic [RW-1:0] pre_q;
    logic [W-1:0]  peak_q;
    logic [W-1:0]  sus_q;
    logic [W-1:0]  atk_q;
    logic [W-1:0]  dec_q;
    logic [W-1:0]  rel_q;

    logic          strobe;
    logic [W:0]    attack_sum;
    logic [W-1:0]  sus_eff;

    assign strobe     = (state_q != ST_IDLE) && (cnt_q == pre_q);
    // One extra bit so level + step can exceed the maximum without wrapping.
    assign attack_sum = {1'b0, level_q} + {1'b0, atk_q};
    assign sus_eff    = (bus.sustain_level < bus.peak_level) ?
                        bus.sustain_level : bus.peak_level;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (bus.note_on) begin
            // Retrigger from any state; level untouched to avoid a click.
            state_d = ST_ATTACK;
            cnt_d   = '0;
        end else if (bus.note_off &&
                     (state_q == ST_ATTACK || state_q == ST_DECAY ||
                      state_q == ST_SUSTAIN)) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
        end else if (state_q == ST_IDLE) begin
            cnt_d   = '0;
            level_d = '0;
        end else begin
            cnt_d = strobe ? '0 : cnt_q + RW'(1);
            case (state_q)
                ST_ATTACK: begin
                    if (strobe) begin
                        if (atk_q == '0 || attack_sum >= {1'b0, peak_q}) begin
                            level_d = peak_q;
                            state_d = ST_DECAY;
                        end else begin
                            level_d = attack_sum[W-1:0];
                        end
                    end
                end
                ST_DECAY: begin
                    if (strobe) begin
                        // Short-circuit keeps the subtraction meaningful:
                        // it is only relevant once level_q > sus_q.
                        if (dec_q == '0 || level_q <= sus_q ||
                            (level_q - sus_q) <= dec_q) begin
                            level_d = sus_q;
                            state_d = ST_SUSTAIN;
                        end else begin
                            level_d = level_q - dec_q;
                        end
                    end
                end
                ST_SUSTAIN: begin
                    level_d = sus_q;
                end
                ST_RELEASE: begin
                    if (strobe) begin
                        if (rel_q == '0 || level_q <= rel_q) begin
                            level_d = '0;
                            state_d = ST_IDLE;
                        end else begin
                            level_d = level_q - rel_q;
                        end
                    end
                end
                default: begin
                    // Non one-hot encodings are unreachable; recover to IDLE.
                    state_d = ST_IDLE;
                    level_d = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            pre_q   <= '0;
            peak_q  <= '0;
            sus_q   <= '0;
            atk_q   <= '0;
            dec_q   <= '0;
            rel_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != ST_IDLE);
            tick_q  <= strobe;
            if (bus.note_on) begin
                pre_q  <= bus.prescale;
                peak_q <= bus.peak_level;
                sus_q  <= sus_eff;
                atk_q  <= bus.attack_step;
                dec_q  <= bus.decay_step;
                rel_q  <= bus.release_step;
            end
        end
    end

    assign bus.level = level_q;
    assign bus.phase = state_q;
    assign bus.busy  = busy_q;
    assign bus.tick  = tick_q;

endmodule

// File: tb/tb_adsr_envelope_gen.sv
// ---------------------------------------------------------------------------
// tb_adsr_envelope_gen
//   Directed bench for adsr_envelope_gen. Expected {gap, phase, level}
//   entries are queued when an event is driven; each tick from the DUT pops
//   one and compares it, where gap is the number of cycles since the
//   previous observation (prescale + 1).
// ---------------------------------------------------------------------------
module tb_adsr_envelope_gen;

    localparam int W  = 8;
    localparam int RW = 16;

    localparam logic [4:0] PH_IDLE    = 5'b00001;
    localparam logic [4:0] PH_ATTACK  = 5'b00010;
    localparam logic [4:0] PH_DECAY   = 5'b00100;
    localparam logic [4:0] PH_SUSTAIN = 5'b01000;
    localparam logic [4:0] PH_RELEASE = 5'b10000;

    localparam int TICK_BUDGET = 60;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    adsr_envelope_gen_if #(.W(W), .RW(RW)) bus ();

    adsr_envelope_gen #(.W(W), .RW(RW)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [W+12:0] exp_q[$];   // {gap[7:0], phase[4:0], level[W-1:0]}
    logic [7:0]    cur_gap;

    // ---------------- driver tasks ----------------
    task automatic cfg(input logic [RW-1:0] p, input logic [W-1:0] pk,
                       input logic [W-1:0] su, input logic [W-1:0] a,
                       input logic [W-1:0] d, input logic [W-1:0] r);
        bus.prescale      = p;
        bus.peak_level    = pk;
        bus.sustain_level = su;
        bus.attack_step   = a;
        bus.decay_step    = d;
        bus.release_step  = r;
        cur_gap           = p[7:0] + 8'd1;
    endtask

    // Drives a one-cycle event from a falling edge; returns at the falling
    // edge right after the event was taken (any tick there is stale).
    task automatic pulse(input logic on, input logic off);
        bus.note_on  = on;
        bus.note_off = off;
        @(posedge clk);
        @(negedge clk);
        bus.note_on  = 1'b0;
        bus.note_off = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] lvl, input logic [4:0] ph);
        exp_q.push_back({cur_gap, ph, lvl});
    endtask

    task automatic drain(input string tag);
        int n;
        int idx;
        logic [W+12:0] e;
        logic [W+12:0] o;
        idx = 0;
        while (exp_q.size() > 0) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.tick && n < TICK_BUDGET);
            e = exp_q.pop_front();
            o = {n[7:0], bus.phase, bus.level};
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL %s[%0d]: got gap=%0d phase=%b level=%0d, expected gap=%0d phase=%b level=%0d",
                       tag, idx, o[W+12:W+5], o[W+4:W], o[W-1:0],
                       e[W+12:W+5], e[W+4:W], e[W-1:0]);
            end
            idx++;
        end
    endtask

    task automatic check_state(input string tag, input logic [W-1:0] exp_level,
                               input logic [4:0] exp_phase);
        logic [W+5:0] obs;
        logic [W+5:0] exp;
        obs = {bus.busy, bus.phase, bus.level};
        exp = {~exp_phase[0], exp_phase, exp_level};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got busy=%b phase=%b level=%0d, expected busy=%b phase=%b level=%0d",
                   tag, obs[W+5], obs[W+4:W], obs[W-1:0],
                   exp[W+5], exp[W+4:W], exp[W-1:0]);
        end
    endtask

    task automatic check_tick(input string tag, input logic exp_tick);
        checks++;
        assert (bus.tick === exp_tick) else begin
            errors++;
            $error("FAIL %s: got tick=%b, expected tick=%b", tag, bus.tick, exp_tick);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_b        = 1'b0;
        bus.note_on  = 1'b0;
        bus.note_off = 1'b0;
        cfg(16'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        #12;
        check_state("reset_state", 8'd0, PH_IDLE);
        check_tick("reset_tick", 1'b0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check_state("after_reset", 8'd0, PH_IDLE);

        // note_off while idle has no effect.
        pulse(1'b0, 1'b1);
        check_state("idle_note_off", 8'd0, PH_IDLE);

        // Asynchronous reset in the middle of an attack.
        cfg(16'd3, 8'd200, 8'd100, 8'd40, 8'd10, 8'd10);
        pulse(1'b1, 1'b0);
        push(8'd40, PH_ATTACK);
        drain("pre_reset_attack");
        #2 rst_b = 1'b0;
        #1;
        check_state("async_reset", 8'd0, PH_IDLE);
        check_tick("async_reset_tick", 1'b0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);

        // Full cycle, prescale 3.
        cfg(16'd3, 8'd200, 8'd100, 8'd50, 8'd30, 8'd40);
        pulse(1'b1, 1'b0);
        check_state("on_latency", 8'd0, PH_ATTACK);
        push(8'd50,  PH_ATTACK);
        push(8'd100, PH_ATTACK);
        push(8'd150, PH_ATTACK);
        push(8'd200, PH_DECAY);
        push(8'd170, PH_DECAY);
        push(8'd140, PH_DECAY);
        push(8'd110, PH_DECAY);
        push(8'd100, PH_SUSTAIN);
        drain("full_attack_decay");
        repeat (7) @(negedge clk);
        check_state("sustain_hold", 8'd100, PH_SUSTAIN);
        pulse(1'b0, 1'b1);
        check_state("release_entry", 8'd100, PH_RELEASE);
        push(8'd60, PH_RELEASE);
        push(8'd20, PH_RELEASE);
        push(8'd0,  PH_IDLE);
        drain("full_release");
        repeat (3) @(negedge clk);
        check_state("full_idle", 8'd0, PH_IDLE);

        // Saturation at the top of the range, then one-strobe release.
        cfg(16'd1, 8'd255, 8'd0, 8'd100, 8'd1, 8'd255);
        pulse(1'b1, 1'b0);
        push(8'd100, PH_ATTACK);
        push(8'd200, PH_ATTACK);
        push(8'd255, PH_DECAY);
        drain("sat_attack");
        pulse(1'b0, 1'b1);
        check_state("sat_release_entry", 8'd255, PH_RELEASE);
        push(8'd0, PH_IDLE);
        drain("sat_release");

        // Early release from attack never visits decay.
        cfg(16'd2, 8'd200, 8'd100, 8'd40, 8'd10, 8'd50);
        pulse(1'b1, 1'b0);
        push(8'd40,  PH_ATTACK);
        push(8'd80,  PH_ATTACK);
        push(8'd120, PH_ATTACK);
        drain("early_attack");
        pulse(1'b0, 1'b1);
        check_state("early_release_entry", 8'd120, PH_RELEASE);
        push(8'd70, PH_RELEASE);
        push(8'd20, PH_RELEASE);
        push(8'd0,  PH_IDLE);
        drain("early_release");

        // Retrigger during release, prescale 0 (events collide with strobes).
        cfg(16'd0, 8'd200, 8'd100, 8'd50, 8'd50, 8'd40);
        pulse(1'b1, 1'b0);
        push(8'd50,  PH_ATTACK);
        push(8'd100, PH_ATTACK);
        push(8'd150, PH_ATTACK);
        push(8'd200, PH_DECAY);
        push(8'd150, PH_DECAY);
        push(8'd100, PH_SUSTAIN);
        drain("retrig_first");
        pulse(1'b0, 1'b1);
        check_state("retrig_off_wins", 8'd100, PH_RELEASE);
        push(8'd60, PH_RELEASE);
        drain("retrig_release");
        pulse(1'b1, 1'b0);
        check_state("retrig_legato", 8'd60, PH_ATTACK);
        push(8'd110, PH_ATTACK);
        push(8'd160, PH_ATTACK);
        push(8'd200, PH_DECAY);
        push(8'd150, PH_DECAY);
        push(8'd100, PH_SUSTAIN);
        drain("retrig_second");
        pulse(1'b1, 1'b1);
        check_state("on_off_same_cycle", 8'd100, PH_ATTACK);
        push(8'd150, PH_ATTACK);
        drain("on_off_attack");
        pulse(1'b0, 1'b1);
        check_state("retrig_release2", 8'd150, PH_RELEASE);
        push(8'd110, PH_RELEASE);
        push(8'd70,  PH_RELEASE);
        push(8'd30,  PH_RELEASE);
        push(8'd0,   PH_IDLE);
        drain("retrig_release_tail");

        // Instant steps, sustain above peak clamps to peak.
        cfg(16'd0, 8'd180, 8'd220, 8'd0, 8'd0, 8'd0);
        pulse(1'b1, 1'b0);
        check_state("instant_entry", 8'd0, PH_ATTACK);
        push(8'd180, PH_DECAY);
        push(8'd180, PH_SUSTAIN);
        drain("instant_attack_decay");
        pulse(1'b0, 1'b1);
        check_state("instant_release_entry", 8'd180, PH_RELEASE);
        push(8'd0, PH_IDLE);
        drain("instant_release");
        @(negedge clk);
        check_state("final_idle", 8'd0, PH_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
